// File: rtl/bit_parity_pkg.sv
// Shared definitions for the XOR-parity bit link.
//   state_t     : receive FSM states (IDLE, DATA, PARITY)
//   PARITY_EVEN : parity mode value 0, XOR of data and parity bit is 0
//   PARITY_ODD  : parity mode value 1, XOR of data and parity bit is 1
//   ERR_CNT_W   : width of the optional parity error counter
//   ERR_CNT_MAX : saturation value of that counter
package bit_parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int                   ERR_CNT_W   = 16;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/parity_acc.sv
// Running XOR parity accumulator, shared by the receive and transmit ends.
// Ports:
//   clk    : clock, rising edge
//   clr    : synchronous clear to 0 (highest priority)
//   load   : start a new accumulation with bit_in as the first bit
//   en     : fold bit_in into the running XOR
//   bit_in : serial bit
//   acc    : current XOR of all bits since the last load
module parity_acc
  import bit_parity_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  logic en,
  input  logic bit_in,
  output logic acc
);

  always_ff @(posedge clk) begin
    if (clr) begin
      acc <= PARITY_EVEN;
    end else if (load) begin
      acc <= bit_in;
    end else if (en) begin
      acc <= acc ^ bit_in;
    end
  end

endmodule

// File: rtl/bit_parity_rx.sv
// Serial receive end of the XOR-parity bit link. Deserialises an LSB-first
// frame of DATA_W data bits plus one parity bit, checks parity and presents
// the word on a valid/ready output register.
// Parameters:
//   DATA_W     : data bits per frame (2..32)
//   PARITY_ODD : 0 = even parity, 1 = odd parity
// Ports:
//   clk_in         : clock, rising edge
//   rst_n_in       : synchronous active-low reset
//   bit_valid_in   : bit_in / sof_in valid this cycle
//   bit_in         : serial bit, data LSB first, then parity
//   sof_in         : first data bit of a frame (restarts any partial frame)
//   data_out       : received word
//   data_valid_out : data_out / parity_err_out valid
//   data_ready_in  : consumer accepts the word
//   parity_err_out : parity mismatch for data_out
//   overrun_out    : one-cycle pulse, completed frame dropped (output full)
//   err_cnt_out    : saturating count of loaded words with a parity error
//                    (only when BIT_PARITY_RX_ERR_CNT_EN is defined)
module bit_parity_rx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              bit_valid_in,
  input  logic              bit_in,
  input  logic              sof_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid_out,
  input  logic              data_ready_in,
  output logic              parity_err_out,
  output logic              overrun_out
`ifdef BIT_PARITY_RX_ERR_CNT_EN
  ,
  output logic [bit_parity_pkg::ERR_CNT_W-1:0] err_cnt_out
`endif
);
  import bit_parity_pkg::*;

  localparam int   CNT_W   = $clog2(DATA_W + 1);
  localparam logic ODD_BIT = (PARITY_ODD != 0);

  function automatic logic calc_parity_err(input logic acc, input logic par);
    return acc ^ par ^ ODD_BIT;
  endfunction

  state_t             state;
  logic [CNT_W-1:0]   cnt_p0;
  logic [DATA_W-1:0]  shift_p0;
  logic               acc_p0;
  logic               frame_done;
  logic               can_load;

  // Stage p0: bit capture, running parity and frame sequencing.
  parity_acc u_parity_acc (
    .clk    (clk_in),
    .clr    (!rst_n_in),
    .load   (bit_valid_in && sof_in),
    .en     (bit_valid_in && (state == DATA)),
    .bit_in (bit_in),
    .acc    (acc_p0)
  );

  // Bits enter at the MSB and move right, so after DATA_W data bits the
  // first (LSB) bit has arrived at position 0.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state    <= IDLE;
      cnt_p0   <= '0;
      shift_p0 <= '0;
    end else if (bit_valid_in) begin
      if (sof_in) begin
        // sof always (re)starts a frame, silently discarding any partial one.
        shift_p0 <= {bit_in, {(DATA_W-1){1'b0}}};
        cnt_p0   <= CNT_W'(1);
        state    <= DATA;
      end else begin
        case (state)
          DATA: begin
            shift_p0 <= {bit_in, shift_p0[DATA_W-1:1]};
            cnt_p0   <= cnt_p0 + CNT_W'(1);
            if (cnt_p0 == CNT_W'(DATA_W - 1)) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            cnt_p0 <= '0;
            state  <= IDLE;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign frame_done = bit_valid_in && !sof_in && (state == PARITY);
  assign can_load   = !data_valid_out || data_ready_in;

  // Stage p1: output register with valid/ready handshake.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      data_out       <= '0;
      parity_err_out <= 1'b0;
      data_valid_out <= 1'b0;
      overrun_out    <= 1'b0;
    end else begin
      overrun_out <= 1'b0;
      if (frame_done && can_load) begin
        data_out       <= shift_p0;
        parity_err_out <= calc_parity_err(acc_p0, bit_in);
        data_valid_out <= 1'b1;
      end else if (frame_done) begin
        overrun_out <= 1'b1;
      end else if (data_ready_in) begin
        data_valid_out <= 1'b0;
      end
    end
  end

`ifdef BIT_PARITY_RX_ERR_CNT_EN
  // Counts only words actually loaded; dropped frames never reach here.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      err_cnt_out <= '0;
    end else if (frame_done && can_load && calc_parity_err(acc_p0, bit_in)
                 && (err_cnt_out != ERR_CNT_MAX)) begin
      err_cnt_out <= err_cnt_out + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_bit_parity_rx.sv
module tb_bit_parity_rx;

  localparam int DATA_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n     = 1'b0;
  logic              bit_valid = 1'b0;
  logic              bit_s     = 1'b0;
  logic              sof       = 1'b0;
  logic              ready     = 1'b0;
  logic [DATA_W-1:0] data_e, data_o;
  logic              vld_e, vld_o, err_e, err_o, ovr_e, ovr_o;
`ifdef BIT_PARITY_RX_ERR_CNT_EN
  logic [15:0]       cnt_e, cnt_o;
  int                exp_cnt_e = 0;
  int                exp_cnt_o = 0;
`endif

  bit_parity_rx #(.DATA_W(DATA_W), .PARITY_ODD(0)) u_even (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .bit_valid_in   (bit_valid),
    .bit_in         (bit_s),
    .sof_in         (sof),
    .data_out       (data_e),
    .data_valid_out (vld_e),
    .data_ready_in  (ready),
    .parity_err_out (err_e),
    .overrun_out    (ovr_e)
`ifdef BIT_PARITY_RX_ERR_CNT_EN
    ,
    .err_cnt_out    (cnt_e)
`endif
  );

  bit_parity_rx #(.DATA_W(DATA_W), .PARITY_ODD(1)) u_odd (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .bit_valid_in   (bit_valid),
    .bit_in         (bit_s),
    .sof_in         (sof),
    .data_out       (data_o),
    .data_valid_out (vld_o),
    .data_ready_in  (ready),
    .parity_err_out (err_o),
    .overrun_out    (ovr_o)
`ifdef BIT_PARITY_RX_ERR_CNT_EN
    ,
    .err_cnt_out    (cnt_o)
`endif
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              err_even;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ovr_cnt_e = 0;
  int   ovr_cnt_o = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor: count overrun pulses and score every accepted word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ovr_e) ovr_cnt_e++;
      if (ovr_o) ovr_cnt_o++;
      if (vld_e && ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {24'h0, data_e}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("even_data", {24'h0, data_e}, {24'h0, mon_e.data});
          check("even_err", {31'h0, err_e}, {31'h0, mon_e.err_even});
          check("odd_valid", {31'h0, vld_o}, 32'h1);
          check("odd_data", {24'h0, data_o}, {24'h0, mon_e.data});
          check("odd_err", {31'h0, err_o}, {31'h0, ~mon_e.err_even});
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic s);
    bit_valid = 1'b1;
    bit_s     = b;
    sof       = s;
    sync();
    bit_valid = 1'b0;
    sof       = 1'b0;
  endtask

  // gap_at: insert two idle cycles after that data bit index (-1 = none).
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p,
                            input int gap_at, input bit rdy_at_par);
    for (int i = 0; i < DATA_W; i++) begin
      send_bit(d[i], i == 0);
      if (i == gap_at) begin
        sync();
        sync();
      end
    end
    if (rdy_at_par) ready = 1'b1;
    send_bit(p, 1'b0);
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic p);
    exp_t e;
    e.data     = d;
    e.err_even = (^d) ^ p;
    exp_q.push_back(e);
`ifdef BIT_PARITY_RX_ERR_CNT_EN
    if (e.err_even) exp_cnt_e++;
    else exp_cnt_o++;
`endif
  endtask

  task automatic drain();
    ready = 1'b1;
    sync();
    sync();
    ready = 1'b0;
    check("drain_valid", {31'h0, vld_e}, 32'h0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, {24'h0, data_e}, 32'h0);
    check({tag, "_valid"}, {30'h0, vld_e, vld_o}, 32'h0);
    check({tag, "_err"}, {30'h0, err_e, err_o}, 32'h0);
    check({tag, "_ovr"}, {30'h0, ovr_e, ovr_o}, 32'h0);
  endtask

  int ovr_before;

  initial begin
    sync();
    sync();
    check_zero("reset");
    rst_n = 1'b1;
    sync();

    // 0xA5 with correct even parity: valid one cycle after the parity bit.
    push(8'hA5, 1'b0);
    send_frame(8'hA5, 1'b0, -1, 1'b0);
    @(negedge clk);
    check("a5_valid", {31'h0, vld_e}, 32'h1);
    check("a5_data", {24'h0, data_e}, 32'hA5);
    check("a5_err", {31'h0, err_e}, 32'h0);
    sync();
    drain();

    // 0xA5 with wrong even parity.
    push(8'hA5, 1'b1);
    send_frame(8'hA5, 1'b1, -1, 1'b0);
    drain();

    // 0x07 with both parity bit values.
    push(8'h07, 1'b0);
    send_frame(8'h07, 1'b0, -1, 1'b0);
    drain();
    push(8'h07, 1'b1);
    send_frame(8'h07, 1'b1, -1, 1'b0);
    drain();

    // Output full: second back-to-back frame dropped with one overrun pulse.
    ovr_before = ovr_cnt_e;
    push(8'h11, 1'b0);
    send_frame(8'h11, 1'b0, -1, 1'b0);
    send_frame(8'h22, 1'b1, -1, 1'b0);
    sync();
    sync();
    check("ovr_pulse_even", ovr_cnt_e - ovr_before, 32'h1);
    check("ovr_pulse_odd", ovr_cnt_o - ovr_before, 32'h1);
    check("ovr_held_data", {24'h0, data_e}, 32'h11);
    drain();

    // Accept in the completion cycle: no loss, no overrun.
    ovr_before = ovr_cnt_e;
    push(8'h11, 1'b0);
    send_frame(8'h11, 1'b0, -1, 1'b0);
    push(8'h22, 1'b0);
    send_frame(8'h22, 1'b0, -1, 1'b1);
    @(negedge clk);
    check("swap_valid", {31'h0, vld_e}, 32'h1);
    sync();
    sync();
    ready = 1'b0;
    check("swap_no_ovr", ovr_cnt_e - ovr_before, 32'h0);
    check("swap_empty", exp_q.size(), 32'h0);

    // Aborted partial frame of ones, then 0x3C with mid-frame gaps.
    ready = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
    sync();
    push(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b0, 3, 1'b0);
    drain();
    check("abort_empty", exp_q.size(), 32'h0);

    // Reset mid-frame while a word is held.
    send_frame(8'h81, 1'b0, -1, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, i == 0);
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
    check_zero("midrst");
`ifdef BIT_PARITY_RX_ERR_CNT_EN
    check("midrst_cnt", {16'h0, cnt_e}, 32'h0);
    exp_cnt_e = 0;
    exp_cnt_o = 0;
`endif
    push(8'h5A, 1'b1);
    send_frame(8'h5A, 1'b1, -1, 1'b0);
    drain();
    check("final_empty", exp_q.size(), 32'h0);
`ifdef BIT_PARITY_RX_ERR_CNT_EN
    check("err_cnt_even", {16'h0, cnt_e}, exp_cnt_e);
    check("err_cnt_odd", {16'h0, cnt_o}, exp_cnt_o);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
